// File: rtl/tree_fanin_pkg.sv
// Shared types and helpers for the tree-node fan-in return path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tree_fanin_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam int unsigned N_CHILD_DEF = 5;
   localparam int unsigned DATA_W_DEF  = 32;

   // Cyclic increment: n-1 wraps to 0.
   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/tree_fanin_rr_pick.sv
// Cyclic first-set finder: first req bit at or after ptr, wrapping through 0.
// Latency: purely combinational.
// Backpressure: none; caller gates the grant with its own load condition.
module tree_fanin_rr_pick #(
   parameter int unsigned N_CHILD = 5,
   parameter int unsigned IDX_W   = $clog2(N_CHILD)
) (
   input  logic [N_CHILD-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int unsigned cand;

   // Walk ptr, ptr+1, ... modulo N_CHILD and keep the first requester found.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < N_CHILD; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= N_CHILD) begin
            cand = cand - N_CHILD;
         end
         if (!gnt_any && req[cand[IDX_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tree_node_fanin_arbiter.sv
// Merges child response beats into one upstream stream, packet-locked round robin, tagged by child index.
// Latency: one cycle (single registered output stage), one beat per cycle sustained.
// Backpressure: up_ready low with a beat held stalls the output and drops every child_ready.
module tree_node_fanin_arbiter
   import tree_fanin_pkg::*;
#(
   parameter int unsigned N_CHILD = N_CHILD_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned IDX_W   = $clog2(N_CHILD),
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CHILD-1:0]        child_valid,
   input  logic [N_CHILD*DATA_W-1:0] child_data,
   input  logic [N_CHILD-1:0]        child_last,
   output logic [N_CHILD-1:0]        child_ready,
   output logic                      up_valid,
   output logic [DATA_W-1:0]         up_data,
   output logic [IDX_W-1:0]          up_idx,
   output logic                      up_last,
   input  logic                      up_ready,
   output logic [CNT_W-1:0]          pkt_count
);

   state_e              state_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    lock_q;
   logic                up_valid_q;
   logic [DATA_W-1:0]   up_data_q;
   logic [IDX_W-1:0]    up_idx_q;
   logic                up_last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;

   logic [IDX_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic [IDX_W-1:0]    sel;
   logic [DATA_W-1:0]   sel_dat;
   logic                sel_lst;
   logic                load_en;
   logic                xfer;

   tree_fanin_rr_pick #(
      .N_CHILD (N_CHILD),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (child_valid),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign load_en = !up_valid_q || up_ready;
   assign sel     = (state_q == ST_LOCKED) ? lock_q : gnt_idx;

   // Steer the selected child's payload; kept off the ready path on purpose.
   always_comb begin
      sel_dat = '0;
      sel_lst = 1'b0;
      for (int i = 0; i < int'(N_CHILD); i++) begin
         if (IDX_W'(i) == sel) begin
            sel_dat = child_data[i*DATA_W +: DATA_W];
            sel_lst = child_last[i];
         end
      end
   end

   // One-hot ready: locked child only while a packet is open, else the round-robin winner.
   always_comb begin
      child_ready = '0;
      if (rst_n && load_en && ((state_q == ST_LOCKED) || gnt_any)) begin
         child_ready[sel] = 1'b1;
      end
   end

   assign xfer = |(child_ready & child_valid);

   // Packet lock FSM; ptr moves only when a packet closes, so grants never interleave.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
      end else if (xfer) begin
         if (state_q == ST_IDLE) begin
            if (sel_lst) begin
               ptr_q <= IDX_W'(next_idx(32'(sel), N_CHILD));
            end else begin
               lock_q  <= sel;
               state_q <= ST_LOCKED;
            end
         end else if (sel_lst) begin
            ptr_q   <= IDX_W'(next_idx(32'(lock_q), N_CHILD));
            state_q <= ST_IDLE;
         end
      end
   end

   // Output stage: reload on any accepted child beat, drain on pop, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_valid_q <= 1'b0;
         up_data_q  <= '0;
         up_idx_q   <= '0;
         up_last_q  <= 1'b0;
      end else if (xfer) begin
         up_valid_q <= 1'b1;
         up_data_q  <= sel_dat;
         up_idx_q   <= sel;
         up_last_q  <= sel_lst;
      end else if (up_ready) begin
         up_valid_q <= 1'b0;
      end
   end

   // Saturating count of packets whose last beat left upstream.
   always_comb begin
      cnt_d = cnt_q;
      if (up_valid_q && up_ready && up_last_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign up_valid  = up_valid_q;
   assign up_data   = up_data_q;
   assign up_idx    = up_idx_q;
   assign up_last   = up_last_q;
   assign pkt_count = cnt_q;

endmodule

// File: tb/tb_tree_node_fanin_arbiter.sv
// Self-checking bench: reference arbiter model feeding a scoreboard, plus directed scenarios.
// Latency: model expects each accepted child beat on up_* in the following cycle.
// Backpressure: up_ready is held low and randomised to exercise stalls.
module tb_tree_node_fanin_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int CW = 4;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    child_valid = '0;
   logic [N*DW-1:0] child_data = '0;
   logic [N-1:0]    child_last = '0;
   logic [N-1:0]    child_ready;
   logic            up_valid;
   logic [DW-1:0]   up_data;
   logic [IW-1:0]   up_idx;
   logic            up_last;
   logic            up_ready = 1'b1;
   logic [CW-1:0]   pkt_count;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tree_node_fanin_arbiter #(
      .N_CHILD (N),
      .DATA_W  (DW),
      .IDX_W   (IW),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .child_valid (child_valid),
      .child_data  (child_data),
      .child_last  (child_last),
      .child_ready (child_ready),
      .up_valid    (up_valid),
      .up_data     (up_data),
      .up_idx      (up_idx),
      .up_last     (up_last),
      .up_ready    (up_ready),
      .pkt_count   (pkt_count)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // ---------------- child sources ----------------
   logic [DW:0]  sm [N][64];
   int           hd [N];
   int           tl [N];
   logic [N-1:0] acc = '0;
   int           seq = 0;

   task automatic push_beat(input int c, input logic l);
      if (hd[c] == tl[c]) begin
         hd[c] = 0;
         tl[c] = 0;
      end
      sm[c][tl[c]] = {l, 8'(c), 24'(seq)};
      seq++;
      tl[c]++;
   endtask

   task automatic drive();
      for (int c = 0; c < N; c++) begin
         if (hd[c] < tl[c]) begin
            child_valid[c]          = 1'b1;
            child_data[c*DW +: DW]  = sm[c][hd[c]][DW-1:0];
            child_last[c]           = sm[c][hd[c]][DW];
         end else begin
            child_valid[c] = 1'b0;
            child_last[c]  = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
         if (acc[c]) hd[c]++;
      end
      drive();
   endtask

   function automatic bit src_empty();
      for (int c = 0; c < N; c++) begin
         if (hd[c] != tl[c]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic drain(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         cyc();
         done = src_empty() && !up_valid;
      end
      if (!done) chk(tag, 0, 1);
   endtask

   task automatic clear_srcs();
      for (int c = 0; c < N; c++) begin
         hd[c] = 0;
         tl[c] = 0;
      end
      drive();
   endtask

   // ---------------- reference model + scoreboard ----------------
   exp_t          sbq[$];
   int            idx_log[$];
   bit            m_lk   = 1'b0;
   int            m_ptr  = 0;
   int            m_lock = 0;
   bit            m_upv  = 1'b0;
   int            m_cnt  = 0;

   // Checks each cycle away from the active edge, then advances the model to the next edge.
   always @(negedge clk) begin
      logic         ld;
      logic [N-1:0] er;
      int           g;
      bit           fnd;
      exp_t         e;
      if (!rst_n) begin
         m_lk = 1'b0; m_ptr = 0; m_lock = 0; m_upv = 1'b0; m_cnt = 0;
         sbq.delete();
         acc = '0;
         chk("rst_ready", child_ready, '0);
      end else begin
         ld  = !m_upv || up_ready;
         er  = '0;
         g   = 0;
         fnd = 1'b0;
         if (m_lk) begin
            g = m_lock;
            if (ld) er[g] = 1'b1;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (!fnd && child_valid[(m_ptr + k) % N]) begin
                  fnd = 1'b1;
                  g   = (m_ptr + k) % N;
               end
            end
            if (fnd && ld) er[g] = 1'b1;
         end
         chk("child_ready", child_ready, er);
         chk("up_valid", up_valid, m_upv);
         chk("pkt_count", pkt_count, m_cnt);
         if (m_upv) begin
            if (sbq.size() == 0) begin
               chk("sb_nonempty", 0, 1);
            end else begin
               e = sbq[0];
               chk("up_data", up_data, e.d);
               chk("up_idx", up_idx, e.idx);
               chk("up_last", up_last, e.l);
               if (up_ready) begin
                  void'(sbq.pop_front());
                  idx_log.push_back(int'(up_idx));
                  if (e.l && m_cnt < 15) m_cnt++;
               end
            end
         end
         acc = child_valid & child_ready;
         if ((er & child_valid) != '0) begin
            e.idx = IW'(g);
            e.d   = child_data[g*DW +: DW];
            e.l   = child_last[g];
            sbq.push_back(e);
            if (!m_lk) begin
               if (child_last[g]) m_ptr = (g + 1) % N;
               else begin m_lk = 1'b1; m_lock = g; end
            end else if (child_last[g]) begin
               m_lk  = 1'b0;
               m_ptr = (g + 1) % N;
            end
            m_upv = 1'b1;
         end else if (up_ready) begin
            m_upv = 1'b0;
         end
      end
   end

   task automatic chk_log(input string tag, input int exp[]);
      chk({tag, "_len"}, idx_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < idx_log.size(); i++) begin
         chk($sformatf("%s_%0d", tag, i), idx_log[i], exp[i]);
      end
      idx_log.delete();
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int t1e[] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
      int t2e[] = '{2, 2, 2, 4, 0};
      int t4e[] = '{3, 1, 2, 0};
      int t5e[] = '{3, 4};
      clear_srcs();
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      chk("reset_up_valid", up_valid, 0);
      chk("reset_pkt_count", pkt_count, 0);
      idx_log.delete();

      // all children valid, single-beat packets
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < N; c++) push_beat(c, 1'b1);
      drain("t1_timeout");
      chk_log("t1_idx", t1e);
      chk("t1_pkt_count", pkt_count, 10);

      // move ptr to 2, then lock on child 2 while 0 and 4 wait
      push_beat(1, 1'b1);
      drain("t2a_timeout");
      idx_log.delete();
      push_beat(2, 1'b0); push_beat(2, 1'b0); push_beat(2, 1'b1);
      push_beat(0, 1'b1); push_beat(4, 1'b1);
      drain("t2_timeout");
      chk_log("t2_idx", t2e);

      // backpressure mid-packet
      for (int b = 0; b < 4; b++) push_beat(3, b == 3);
      repeat (3) cyc();
      up_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         cyc();
         chk("t3_stall_ready", child_ready, '0);
         chk("t3_stall_valid", up_valid, 1);
      end
      up_ready = 1'b1;
      drain("t3_timeout");

      // random traffic with random stalls
      for (int i = 0; i < 80; i++) begin
         int c;
         c = int'($urandom_range(0, N - 1));
         if (hd[c] == tl[c] && $urandom_range(0, 2) == 0) begin
            int len;
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++) push_beat(c, b == len - 1);
         end
         up_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      up_ready = 1'b1;
      drain("rand_timeout");
      idx_log.delete();

      // wrap: ptr to 4, then only child 1
      push_beat(3, 1'b1);
      drain("t4a_timeout");
      push_beat(1, 1'b1);
      drain("t4b_timeout");
      push_beat(0, 1'b1); push_beat(2, 1'b1);
      drain("t4c_timeout");
      chk_log("t4_idx", t4e);

      // asynchronous reset in the middle of a 4-beat packet
      for (int b = 0; b < 4; b++) push_beat(1, b == 3);
      repeat (3) cyc();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_up_valid", up_valid, 0);
      chk("t5_async_up_data", up_data, 0);
      chk("t5_async_up_idx", up_idx, 0);
      chk("t5_async_up_last", up_last, 0);
      chk("t5_async_pkt_count", pkt_count, 0);
      chk("t5_async_ready", child_ready, '0);
      clear_srcs();
      repeat (2) cyc();
      rst_n = 1'b1;
      idx_log.delete();
      push_beat(3, 1'b1); push_beat(4, 1'b1);
      drain("t5_timeout");
      chk_log("t5_idx", t5e);
      chk("t5_pkt_count", pkt_count, 2);

      // counter saturation
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < N; c++) push_beat(c, 1'b1);
      drain("t6_timeout");
      chk("t6_sat", pkt_count, 15);
      repeat (3) cyc();
      chk("t6_sat_hold", pkt_count, 15);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
